// File: rtl/event_window_dispatcher_if.sv
// Event-FIFO side and target-output side of event_window_dispatcher.
// master = dispatcher, slave = FIFO plus downstream consumer.
interface event_window_dispatcher_if #(
    parameter int COORD_WIDTH = 8,
    parameter int KERNEL_SIZE = 3
);
    localparam int KW = $clog2(KERNEL_SIZE);

    logic                     fifo_empty;
    logic                     fifo_read_en;
    logic [2*COORD_WIDTH-1:0] fifo_read_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [COORD_WIDTH-1:0]   out_x;
    logic [COORD_WIDTH-1:0]   out_y;
    logic [KW-1:0]            out_kx;
    logic [KW-1:0]            out_ky;

    modport master (
        input  fifo_empty, fifo_read_data, out_ready,
        output fifo_read_en, out_valid, out_x, out_y, out_kx, out_ky
    );

    modport slave (
        output fifo_empty, fifo_read_data, out_ready,
        input  fifo_read_en, out_valid, out_x, out_y, out_kx, out_ky
    );
endinterface

// File: rtl/event_window_dispatcher.sv
// Pops spike events from the event FIFO and walks each KxK neighbourhood, emitting in-bounds targets.
// Define DISPATCH_STATS_EN to build the event/drop statistics counters; otherwise they read 0.
module event_window_dispatcher #(
    parameter int COORD_WIDTH = 8,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    event_window_dispatcher_if.master  bus,
    output logic                       event_done,
    output logic                       drop_pulse,
    output logic                       busy,
    output logic [15:0]                event_count,
    output logic [15:0]                drop_count
);
    localparam int KW = $clog2(KERNEL_SIZE);
    localparam int R  = (KERNEL_SIZE - 1) / 2;
    localparam int SW = COORD_WIDTH + 2;
    localparam logic signed [SW-1:0] R_S    = SW'(R);
    localparam logic signed [SW-1:0] W_S    = SW'(IMG_WIDTH);
    localparam logic signed [SW-1:0] H_S    = SW'(IMG_HEIGHT);
    localparam logic [KW-1:0]        K_LAST = KW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SCAN} state_e;

    state_e                 state_q, state_d;
    logic [COORD_WIDTH-1:0] ev_x_q, ev_x_d, ev_y_q, ev_y_d;
    logic [KW-1:0]          kx_q, kx_d, ky_q, ky_d;
    logic                   event_done_q, event_done_d;
    logic                   drop_pulse_q, drop_pulse_d;

    logic [COORD_WIDTH-1:0] in_x, in_y;
    logic                   in_range;
    logic signed [SW-1:0]   tx, ty;
    logic                   tap_in_bounds, tap_last;
    logic                   valid_c;

    assign in_x     = bus.fifo_read_data[2*COORD_WIDTH-1:COORD_WIDTH];
    assign in_y     = bus.fifo_read_data[COORD_WIDTH-1:0];
    assign in_range = ($signed({2'b00, in_x}) < W_S) && ($signed({2'b00, in_y}) < H_S);

    // Two guard bits keep the signed offset exact for edge events.
    assign tx = $signed({2'b00, ev_x_q}) + $signed({{(SW-KW){1'b0}}, kx_q}) - R_S;
    assign ty = $signed({2'b00, ev_y_q}) + $signed({{(SW-KW){1'b0}}, ky_q}) - R_S;

    assign tap_in_bounds = !tx[SW-1] && (tx < W_S) && !ty[SW-1] && (ty < H_S);
    assign tap_last      = (kx_q == K_LAST) && (ky_q == K_LAST);

    always_comb begin
        state_d          = state_q;
        ev_x_d           = ev_x_q;
        ev_y_d           = ev_y_q;
        kx_d             = kx_q;
        ky_d             = ky_q;
        event_done_d     = 1'b0;
        drop_pulse_d     = 1'b0;
        bus.fifo_read_en = 1'b0;
        valid_c          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.fifo_read_en = enable && !bus.fifo_empty;
                if (bus.fifo_read_en) state_d = LATCH;
            end
            LATCH: begin
                ev_x_d = in_x;
                ev_y_d = in_y;
                if (!in_range) begin
                    drop_pulse_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    kx_d    = '0;
                    ky_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                valid_c = tap_in_bounds;
                // Skipped taps advance unconditionally; real targets wait for out_ready.
                if (!tap_in_bounds || bus.out_ready) begin
                    if (tap_last) begin
                        event_done_d = 1'b1;
                        state_d      = IDLE;
                    end else if (kx_q == K_LAST) begin
                        kx_d = '0;
                        ky_d = ky_q + KW'(1);
                    end else begin
                        kx_d = kx_q + KW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ev_x_q       <= '0;
            ev_y_q       <= '0;
            kx_q         <= '0;
            ky_q         <= '0;
            event_done_q <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ev_x_q       <= ev_x_d;
            ev_y_q       <= ev_y_d;
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            event_done_q <= event_done_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign bus.out_valid = valid_c;
    assign bus.out_x     = valid_c ? tx[COORD_WIDTH-1:0] : '0;
    assign bus.out_y     = valid_c ? ty[COORD_WIDTH-1:0] : '0;
    assign bus.out_kx    = valid_c ? kx_q : '0;
    assign bus.out_ky    = valid_c ? ky_q : '0;
    assign event_done    = event_done_q;
    assign drop_pulse    = drop_pulse_q;
    assign busy          = (state_q != IDLE);

`ifdef DISPATCH_STATS_EN
    logic [15:0] event_count_q, event_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        event_count_d = event_count_q + {15'd0, event_done_d};
        drop_count_d  = drop_count_q + {15'd0, drop_pulse_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            event_count_q <= event_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign event_count = event_count_q;
    assign drop_count  = drop_count_q;
`else
    assign event_count = '0;
    assign drop_count  = '0;
`endif
endmodule

// File: tb/tb_event_window_dispatcher.sv
// Directed bench for event_window_dispatcher: FIFO model, per-cycle reference model, literal anchors.
module tb_event_window_dispatcher;
    localparam int CW = 8;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int K  = 3;
    localparam int R  = (K - 1) / 2;
`ifdef DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        event_done, drop_pulse, busy;
    logic [15:0] event_count, drop_count;

    event_window_dispatcher_if #(.COORD_WIDTH(CW), .KERNEL_SIZE(K)) bus ();

    event_window_dispatcher #(
        .COORD_WIDTH(CW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
        .event_done(event_done), .drop_pulse(drop_pulse), .busy(busy),
        .event_count(event_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Event FIFO with a registered read port
    logic [2*CW-1:0] fq [64];
    int unsigned     wr_ptr = 0;
    int unsigned     rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (bus.fifo_read_en) begin
            bus.fifo_read_data <= fq[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic push(input int x, input int y);
        fq[wr_ptr % 64] = {x[CW-1:0], y[CW-1:0]};
        wr_ptr++;
    endtask

    // Reference model: phase 0 idle, 1 event being latched, 2 walking the window
    typedef struct {int x; int y; int kx; int ky; bit inb;} tap_t;
    tap_t taps[$];
    int   m_phase = 0;
    bit   m_done_pend = 0, m_drop_pend = 0;
    int   m_ex, m_ey, m_events = 0, m_drops = 0;
    bit   exp_rd;
    logic [2*CW-1:0] popped;
    int   cyc = 0, pop_cnt = 0, done_cnt = 0, drop_seen = 0;
    int   last_pop_cyc = 0, last_done_cyc = 0, last_drop_cyc = 0;
    int   acc_x[$], acc_y[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_read_en", bus.fifo_read_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", event_done, 0);
            chk("rst_drop", drop_pulse, 0);
            chk("rst_out_xy", {bus.out_x, bus.out_y}, 0);
            chk("rst_out_k", {bus.out_kx, bus.out_ky}, 0);
            chk("rst_counts", {event_count, drop_count}, 0);
            m_phase = 0; taps.delete(); m_done_pend = 0; m_drop_pend = 0;
            m_events = 0; m_drops = 0;
        end else begin
            exp_rd = (m_phase == 0) && enable && !bus.fifo_empty;
            chk("busy", busy, int'(m_phase != 0));
            chk("fifo_read_en", bus.fifo_read_en, int'(exp_rd));
            chk("event_done", event_done, int'(m_done_pend));
            chk("drop_pulse", drop_pulse, int'(m_drop_pend));
            chk("event_count", event_count, STATS ? (m_events % 65536) : 0);
            chk("drop_count", drop_count, STATS ? (m_drops % 65536) : 0);
            if (m_phase == 2) begin
                chk("out_valid", bus.out_valid, int'(taps[0].inb));
                if (taps[0].inb) begin
                    chk("out_x", bus.out_x, taps[0].x);
                    chk("out_y", bus.out_y, taps[0].y);
                    chk("out_kx", bus.out_kx, taps[0].kx);
                    chk("out_ky", bus.out_ky, taps[0].ky);
                end
            end else begin
                chk("out_valid_idle", bus.out_valid, 0);
            end

            if (bus.fifo_read_en) begin pop_cnt++; last_pop_cyc = cyc; end
            if (event_done) begin done_cnt++; last_done_cyc = cyc; end
            if (drop_pulse) begin drop_seen++; last_drop_cyc = cyc; end
            if (bus.out_valid && bus.out_ready) begin
                acc_x.push_back(int'(bus.out_x));
                acc_y.push_back(int'(bus.out_y));
            end

            m_done_pend = 0;
            m_drop_pend = 0;
            case (m_phase)
                0: if (exp_rd) begin
                    popped  = fq[rd_ptr % 64];
                    m_ex    = int'(popped[2*CW-1:CW]);
                    m_ey    = int'(popped[CW-1:0]);
                    m_phase = 1;
                end
                1: if (m_ex >= W || m_ey >= H) begin
                    m_drop_pend = 1; m_drops++; m_phase = 0;
                end else begin
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            tap_t t;
                            t.x = m_ex + kx - R; t.y = m_ey + ky - R;
                            t.kx = kx; t.ky = ky;
                            t.inb = (t.x >= 0) && (t.x < W) && (t.y >= 0) && (t.y < H);
                            taps.push_back(t);
                        end
                    m_phase = 2;
                end
                default: begin
                    if (!taps[0].inb || bus.out_ready) void'(taps.pop_front());
                    if (taps.size() == 0) begin
                        m_done_pend = 1; m_events++; m_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 200) begin tick(); n++; end
        chk(name, done_cnt, target);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        chk(name, bus.out_valid, 1);
    endtask

    task automatic chk_beat(input string name, input int idx, input int ex, input int ey);
        if (idx < acc_x.size()) begin
            chk({name, "_x"}, acc_x[idx], ex);
            chk({name, "_y"}, acc_y[idx], ey);
        end else begin
            chk({name, "_missing"}, -1, idx);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    int b, t, p, n;
    int cx2[4] = '{0, 1, 0, 1};
    int cy2[4] = '{0, 0, 1, 1};
    int cx3[4] = '{30, 31, 30, 31};
    int cy3[4] = '{30, 30, 31, 31};

    initial begin
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        enable = 1'b1;

        // Centre event: full 3x3 window in raster order
        b = acc_x.size(); t = done_cnt + 1;
        push(5, 5);
        wait_done(t, "t1_done");
        chk("t1_beats", acc_x.size() - b, 9);
        for (int i = 0; i < 9; i++)
            chk_beat($sformatf("t1_beat%0d", i), b + i, 4 + i % 3, 4 + i / 3);
        chk("t1_latency", last_done_cyc - last_pop_cyc, 11);

        // Corner event: only four in-bounds taps, same latency
        b = acc_x.size(); t = done_cnt + 1;
        push(0, 0);
        wait_done(t, "t2_done");
        chk("t2_beats", acc_x.size() - b, 4);
        for (int i = 0; i < 4; i++)
            chk_beat($sformatf("t2_beat%0d", i), b + i, cx2[i], cy2[i]);
        chk("t2_latency", last_done_cyc - last_pop_cyc, 11);

        // Far corner with backpressure on the first beat
        bus.out_ready = 1'b0;
        b = acc_x.size(); t = done_cnt + 1;
        push(31, 31);
        wait_valid("t3_valid");
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_x", bus.out_x, 30);
            chk("t3_hold_y", bus.out_y, 30);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_done(t, "t3_done");
        chk("t3_beats", acc_x.size() - b, 4);
        for (int i = 0; i < 4; i++)
            chk_beat($sformatf("t3_beat%0d", i), b + i, cx3[i], cy3[i]);
        chk("t3_latency", last_done_cyc - last_pop_cyc, 14);

        // Out-of-range event is dropped
        b = acc_x.size(); t = drop_seen + 1; n = 0;
        push(40, 3);
        while (drop_seen < t && n < 20) begin tick(); n++; end
        chk("t4_drop_seen", drop_seen, t);
        chk("t4_drop_latency", last_drop_cyc - last_pop_cyc, 2);
        chk("t4_beats", acc_x.size() - b, 0);
        tick();
        chk("t4_busy", busy, 0);
        chk("t4_drop_count", drop_count, STATS ? 1 : 0);

        // Two queued events, enable dropped during the first window
        do_reset();
        p = pop_cnt; t = done_cnt + 1; n = 0;
        push(10, 10);
        push(20, 20);
        while (!busy && n < 20) begin tick(); n++; end
        chk("t5_busy", busy, 1);
        enable = 1'b0;
        wait_done(t, "t5_done1");
        repeat (6) tick();
        chk("t5_pops_held", pop_cnt - p, 1);
        chk("t5_count1", event_count, STATS ? 1 : 0);
        enable = 1'b1;
        wait_done(t + 1, "t5_done2");
        chk("t5_pops", pop_cnt - p, 2);
        chk("t5_count2", event_count, STATS ? 2 : 0);

        // Reset mid-window, then a fresh event
        push(16, 16);
        wait_valid("t6_valid");
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t6_valid_zero", bus.out_valid, 0);
        chk("t6_busy_zero", busy, 0);
        chk("t6_xy_zero", {bus.out_x, bus.out_y}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        b = acc_x.size(); t = done_cnt + 1;
        push(2, 7);
        wait_done(t, "t6_done");
        chk("t6_beats", acc_x.size() - b, 9);
        chk_beat("t6_first", b, 1, 6);
        chk_beat("t6_last", b + 8, 3, 8);
        chk("t6_count", event_count, STATS ? 1 : 0);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/event_window_dispatcher.md
# event_window_dispatcher

Drains spike events from the convolution input event FIFO and expands each event into the KERNEL_SIZE×KERNEL_SIZE neighbourhood of target neuron coordinates for the downstream membrane-update stage. Sits directly downstream of the event FIFO: it drives the FIFO read enable, accounts for the FIFO's one-cycle registered read latency, and issues one target per accepted valid/ready beat. Out-of-bounds targets are skipped; malformed events are dropped.

## Interface
- COORD_WIDTH, 8, width of one coordinate; event word is {x, y}
- IMG_WIDTH, 32, feature-map width (x range 0..IMG_WIDTH-1)
- IMG_HEIGHT, 32, feature-map height
- KERNEL_SIZE, 3, odd kernel size; radius R = (KERNEL_SIZE-1)/2
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  permits fetching new events
- fifo_empty  in  1  FIFO empty flag
- fifo_read_en  out  1  FIFO pop request
- fifo_read_data  in  2*COORD_WIDTH  event; [2*CW-1:CW]=x, [CW-1:0]=y; valid cycle after pop
- out_valid  out  1  target valid
- out_ready  in  1  downstream accepts target
- out_x, out_y  out  COORD_WIDTH each  target neuron coordinate
- out_kx, out_ky  out  $clog2(KERNEL_SIZE) each  kernel tap index
- event_done  out  1  one-cycle pulse: event window fully scanned
- drop_pulse  out  1  one-cycle pulse: event dropped as out of range
- busy  out  1  state != IDLE
- event_count, drop_count  out  16 each  statistics (see Configuration)

## Operation
- States: IDLE, LATCH, SCAN.
- IDLE: fifo_read_en = enable && !fifo_empty (combinational, only in IDLE); if asserted → LATCH.
- LATCH: capture fifo_read_data into ev_x/ev_y; if ev_x >= IMG_WIDTH or ev_y >= IMG_HEIGHT → pulse drop_pulse next cycle, → IDLE; else kx=ky=0, → SCAN.
- SCAN: tx = ev_x + kx - R, ty = ev_y + ky - R, computed signed in COORD_WIDTH+2 bits. In-bounds iff 0 <= tx < IMG_WIDTH and 0 <= ty < IMG_HEIGHT.
  - In-bounds: out_valid=1; advance tap only on out_ready.
  - Out-of-bounds: out_valid=0; advance tap unconditionally (one cycle per skipped tap).
  - Tap order: ky outer, kx inner, 0..KERNEL_SIZE-1. Advancing from (K-1,K-1): event_done pulse next cycle, → IDLE.
- out_x/out_y = tx/ty low COORD_WIDTH bits; out_kx/out_ky = kx/ky; all stable while out_valid && !out_ready.
- enable deasserted mid-event: current window completes; no new pop.
- No pop is issued in LATCH or SCAN; at most one event in flight.

## Timing
- Reset: state IDLE, fifo_read_en 0, out_valid 0, out_x/out_y/out_kx/out_ky 0, event_done 0, drop_pulse 0, busy 0, counters 0.
- Pop in cycle N → LATCH in N+1 → first tap in N+2.
- With out_ready held high: K*K SCAN cycles per event regardless of skips; event_done in cycle N+2+K*K; next pop no earlier than that same cycle (IDLE).
- Dropped event: drop_pulse at N+2, next pop no earlier than N+2.
- Reset mid-SCAN: window abandoned, popped event lost, no event_done.

## Configuration
- DISPATCH_STATS_EN defined: event_count increments (wrapping) on each event_done; drop_count increments (wrapping) on each drop_pulse.
- Not defined: counters not instantiated; event_count and drop_count tied to 0. Dispatch behaviour identical.

## Test plan
- Event (5,5), K=3, out_ready=1: 9 beats (4,4),(5,4),(6,4),(4,5)…(6,6) in order; event_done 11 cycles after pop.
- Corner event (0,0): exactly 4 beats (0,0),(1,0),(0,1),(1,1); event_done still 11 cycles after pop.
- Event (31,31) with out_ready low 3 cycles at first beat: (30,30) held stable 3 cycles, then 4 beats total, no loss.
- Event (40,3) on 32×32: no out_valid, drop_pulse at pop+2, drop_count=1 (with DISPATCH_STATS_EN), busy low after.
- Two events queued, enable dropped during first SCAN: first window completes, no second pop until enable returns; event_count=1 then 2.
- rst_n asserted mid-SCAN: all outputs 0 immediately; after release, fresh event processed normally.
